// File: rtl/dispatch_scheduler_pkg.sv
// Shared definitions for the dual-issue dispatch controller: decoded-entry
// field layout, instruction class codes and serializing FSM states.
package dispatch_scheduler_pkg;

  localparam int DECODE_DATA_WIDTH = 32;

  localparam int F_VALID  = 0;
  localparam int F_RD     = 1;
  localparam int F_RJ     = 6;
  localparam int F_RK     = 11;
  localparam int F_RD_WEN = 16;
  localparam int F_CLASS  = 17;

  localparam int REG_W   = 5;
  localparam int CLASS_W = 3;

  typedef enum logic [CLASS_W-1:0] {
    CLS_ALU    = 3'd0,
    CLS_MEM    = 3'd1,
    CLS_MULDIV = 3'd2,
    CLS_BR     = 3'd3,
    CLS_SERIAL = 3'd4
  } class_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_ISSUE_SER = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dispatch_scheduler_pair_check.sv
// Decides whether the head+1 entry may issue alongside the head entry:
// blocks on a RAW hazard against slot 0's destination and on shared units.
module dispatch_pair_check
  import dispatch_scheduler_pkg::*;
(
  input  logic [REG_W-1:0] i_rd0,
  input  logic             i_rd_wen0,
  input  class_e           i_class0,
  input  logic [REG_W-1:0] i_rj1,
  input  logic [REG_W-1:0] i_rk1,
  input  class_e           i_class1,
  output logic             o_pair_ok
);

  logic w_raw;
  logic w_both_mem;
  logic w_both_muldiv;

  // r0 is hardwired zero, so writing it never creates a dependency
  assign w_raw = i_rd_wen0 && (i_rd0 != '0) && ((i_rd0 == i_rj1) || (i_rd0 == i_rk1));
  assign w_both_mem    = (i_class0 == CLS_MEM)    && (i_class1 == CLS_MEM);
  assign w_both_muldiv = (i_class0 == CLS_MULDIV) && (i_class1 == CLS_MULDIV);

  assign o_pair_ok = !(w_raw || w_both_mem || w_both_muldiv);

endmodule

// File: rtl/dispatch_scheduler.sv
// Dual-issue dispatch controller: picks 0-2 FIFO head entries per cycle,
// loads them into a registered issue stage and serializes CSR-class entries.
module dispatch_scheduler
  import dispatch_scheduler_pkg::*;
#(
  parameter int DATA_W = DECODE_DATA_WIDTH,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] fifo_data1,
  input  logic [DATA_W-1:0] fifo_data2,
  output logic [1:0]        invalid_en,
  input  logic              issue_ready,
  input  logic              backend_empty,
  input  logic              serial_done,
  output logic [1:0]        issue_valid,
  output logic [DATA_W-1:0] issue_data1,
  output logic [DATA_W-1:0] issue_data2,
  output logic              serial_busy,
  output logic [CNT_W-1:0]  perf_issue_cnt,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output state_e            dbg_state
);

  // Handshake: the issue register is consumed on a clock edge where
  // issue_valid[0] && issue_ready; it may be reloaded on that same edge.

  state_e            r_state;
  state_e            w_state_nxt;
  logic [1:0]        r_issue_valid;
  logic [DATA_W-1:0] r_issue_data1;
  logic [DATA_W-1:0] r_issue_data2;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic   w_v0, w_v1;
  class_e w_class0, w_class1;
  logic   w_ser0, w_ser1;
  logic   w_can_load;
  logic   w_permit0;
  logic   w_pair_state;
  logic   w_pair_ok;
  logic   w_t0, w_t1;

  assign w_v0     = fifo_data1[F_VALID];
  assign w_v1     = fifo_data2[F_VALID];
  assign w_class0 = class_e'(fifo_data1[F_CLASS +: CLASS_W]);
  assign w_class1 = class_e'(fifo_data2[F_CLASS +: CLASS_W]);
  assign w_ser0   = (w_class0 == CLS_SERIAL);
  assign w_ser1   = (w_class1 == CLS_SERIAL);

  assign w_can_load = !r_issue_valid[0] || issue_ready;

  dispatch_pair_check u_pair_check (
    .i_rd0     (fifo_data1[F_RD +: REG_W]),
    .i_rd_wen0 (fifo_data1[F_RD_WEN]),
    .i_class0  (w_class0),
    .i_rj1     (fifo_data2[F_RJ +: REG_W]),
    .i_rk1     (fifo_data2[F_RK +: REG_W]),
    .i_class1  (w_class1),
    .o_pair_ok (w_pair_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      if (w_v0 && w_ser0) w_state_nxt = ST_DRAIN;
        ST_DRAIN:     if (backend_empty && !r_issue_valid[0]) w_state_nxt = ST_ISSUE_SER;
        ST_ISSUE_SER: if (w_t0) w_state_nxt = ST_WAIT_DONE;
        ST_WAIT_DONE: if (serial_done) w_state_nxt = ST_IDLE;
        default:      w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_permit0    = 1'b0;
    w_pair_state = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_permit0    = !w_ser0;
        w_pair_state = 1'b1;
      end
      ST_ISSUE_SER: w_permit0 = w_ser0;
      default: ;
    endcase
  end

  // Gating with rst keeps the dequeue vector quiet while reset is held
  assign w_t0 = rst && w_v0 && w_can_load && !flush && w_permit0;
  assign w_t1 = w_t0 && w_v1 && w_pair_state && !w_ser1 && w_pair_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_valid <= '0;
      r_issue_data1 <= '0;
      r_issue_data2 <= '0;
    end else if (flush) begin
      r_issue_valid <= '0;
    end else if (w_can_load) begin
      r_issue_valid <= {w_t1, w_t0};
      if (w_t0) r_issue_data1 <= fifo_data1;
      if (w_t1) r_issue_data2 <= fifo_data2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_issue_cnt <= r_issue_cnt + CNT_W'(w_t0) + CNT_W'(w_t1);
      if (w_v0 && !flush && !w_t0) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign invalid_en     = {w_t1, w_t0};
  assign issue_valid    = r_issue_valid;
  assign issue_data1    = r_issue_data1;
  assign issue_data2    = r_issue_data2;
  assign serial_busy    = (r_state != ST_IDLE);
  assign perf_issue_cnt = r_issue_cnt;
  assign perf_stall_cnt = r_stall_cnt;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler: stimulus pushes expected issue-stage
// contents, a monitor pops and compares them on every accepted issue.
module tb_dispatch_scheduler;
  import dispatch_scheduler_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] fifo_data1, fifo_data2;
  logic [1:0]  invalid_en;
  logic        issue_ready, backend_empty, serial_done;
  logic [1:0]  issue_valid;
  logic [31:0] issue_data1, issue_data2;
  logic        serial_busy;
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
  state_e      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [65:0] exp_q[$];

  dispatch_scheduler #(.DATA_W(32), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fifo_data1     (fifo_data1),
    .fifo_data2     (fifo_data2),
    .invalid_en     (invalid_en),
    .issue_ready    (issue_ready),
    .backend_empty  (backend_empty),
    .serial_done    (serial_done),
    .issue_valid    (issue_valid),
    .issue_data1    (issue_data1),
    .issue_data2    (issue_data2),
    .serial_busy    (serial_busy),
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // entry layout: valid[0] rd[5:1] rj[10:6] rk[15:11] wen[16] class[19:17] tag[31:20]
  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rj,
                                     input logic [4:0] rk, input logic wen,
                                     input logic [2:0] cls, input logic [11:0] tag);
    logic [31:0] e;
    e        = '0;
    e[0]     = 1'b1;
    e[5:1]   = rd;
    e[10:6]  = rj;
    e[15:11] = rk;
    e[16]    = wen;
    e[19:17] = cls;
    e[31:20] = tag;
    return e;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_fifo(input logic [31:0] a, input logic [31:0] b);
    fifo_data1 = a;
    fifo_data2 = b;
  endtask

  task automatic push(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back({v, a, (v[1] ? b : 32'h0)});
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every accepted issue register is compared
  always @(negedge clk) begin
    logic [65:0] e;
    logic [65:0] a;
    if (rst && !flush && issue_valid[0] && issue_ready) begin
      n_vec++;
      a = {issue_valid, issue_data1, (issue_valid[1] ? issue_data2 : 32'h0)};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_pop: unexpected issue %0h with empty queue", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_err++;
          $display("FAIL issue_pop: got %0h expected %0h", a, e);
        end
      end
    end
  end

  logic [31:0] a1, a2, b1, b2, c1, c2, m1, m2, m3, m4;
  logic [31:0] p1, p2, q1, q2, s1, s2, s3, u1, u2, u3, r1, f1, f2;

  initial begin
    a1 = mk(5'd5, 5'd0, 5'd0, 1'b1, CLS_ALU, 12'd1);
    a2 = mk(5'd8, 5'd6, 5'd0, 1'b1, CLS_ALU, 12'd2);
    b1 = mk(5'd7, 5'd0, 5'd0, 1'b1, CLS_ALU, 12'd3);
    b2 = mk(5'd9, 5'd7, 5'd0, 1'b1, CLS_ALU, 12'd4);
    c1 = mk(5'd0, 5'd1, 5'd2, 1'b1, CLS_ALU, 12'd5);
    c2 = mk(5'd3, 5'd0, 5'd4, 1'b1, CLS_ALU, 12'd6);
    m1 = mk(5'd10, 5'd1, 5'd2, 1'b1, CLS_MEM, 12'd7);
    m2 = mk(5'd11, 5'd3, 5'd4, 1'b1, CLS_MEM, 12'd8);
    m3 = mk(5'd12, 5'd1, 5'd1, 1'b1, CLS_MEM, 12'd9);
    m4 = mk(5'd13, 5'd2, 5'd2, 1'b1, CLS_MULDIV, 12'd10);
    p1 = mk(5'd14, 5'd1, 5'd1, 1'b1, CLS_ALU, 12'd11);
    p2 = mk(5'd15, 5'd2, 5'd2, 1'b1, CLS_BR, 12'd12);
    q1 = mk(5'd16, 5'd3, 5'd3, 1'b1, CLS_ALU, 12'd13);
    q2 = mk(5'd17, 5'd4, 5'd4, 1'b1, CLS_ALU, 12'd14);
    s1 = mk(5'd0, 5'd0, 5'd0, 1'b0, CLS_SERIAL, 12'd15);
    s2 = mk(5'd18, 5'd1, 5'd1, 1'b1, CLS_ALU, 12'd16);
    s3 = mk(5'd19, 5'd2, 5'd2, 1'b1, CLS_ALU, 12'd17);
    u1 = mk(5'd0, 5'd0, 5'd0, 1'b0, CLS_SERIAL, 12'd18);
    u2 = mk(5'd20, 5'd1, 5'd1, 1'b1, CLS_ALU, 12'd19);
    u3 = mk(5'd21, 5'd2, 5'd2, 1'b1, CLS_ALU, 12'd20);
    r1 = mk(5'd0, 5'd0, 5'd0, 1'b0, CLS_SERIAL, 12'd21);
    f1 = mk(5'd22, 5'd1, 5'd1, 1'b1, CLS_ALU, 12'd22);
    f2 = mk(5'd23, 5'd2, 5'd2, 1'b1, CLS_ALU, 12'd23);

    rst = 1'b0; flush = 1'b0; issue_ready = 1'b1; backend_empty = 1'b1; serial_done = 1'b0;
    set_fifo(a1, a2);
    repeat (2) @(posedge clk);
    neg();
    chk("rst_invalid_en", invalid_en, 2'b00);
    chk("rst_issue_valid", issue_valid, 2'b00);
    chk("rst_serial_busy", serial_busy, 1'b0);
    chk("rst_issue_cnt", perf_issue_cnt, 0);
    chk("rst_stall_cnt", perf_stall_cnt, 0);
    chk("rst_state", dbg_state, ST_IDLE);

    // independent ALU pair
    step(); rst = 1'b1;
    neg(); chk("pair_alu_inv", invalid_en, 2'b11); push(2'b11, a1, a2);
    step(); set_fifo(32'h0, 32'h0);
    neg(); chk("pair_alu_valid", issue_valid, 2'b11); chk("pair_alu_cnt", perf_issue_cnt, 2);

    // RAW hazard splits the pair, rd0 = 0 does not
    step(); set_fifo(b1, b2);
    neg(); chk("raw_inv", invalid_en, 2'b01); push(2'b01, b1, 32'h0);
    step(); set_fifo(b2, 32'h0);
    neg(); chk("raw_second_inv", invalid_en, 2'b01); push(2'b01, b2, 32'h0);
    step(); set_fifo(c1, c2);
    neg(); chk("raw_r0_inv", invalid_en, 2'b11); push(2'b11, c1, c2);

    // structural conflicts
    step(); set_fifo(m1, m2);
    neg(); chk("mem_mem_inv", invalid_en, 2'b01); push(2'b01, m1, 32'h0);
    step(); set_fifo(m2, 32'h0);
    neg(); chk("mem_mem_second_inv", invalid_en, 2'b01); push(2'b01, m2, 32'h0);
    step(); set_fifo(m3, m4);
    neg(); chk("mem_muldiv_inv", invalid_en, 2'b11); push(2'b11, m3, m4);
    step(); set_fifo(32'h0, 32'h0);
    neg(); chk("struct_issue_cnt", perf_issue_cnt, 10); chk("struct_stall_cnt", perf_stall_cnt, 0);

    // backpressure: issue register holds, stall counts
    step(); set_fifo(p1, p2);
    neg(); chk("bp_load_inv", invalid_en, 2'b11); push(2'b11, p1, p2);
    step(); issue_ready = 1'b0; set_fifo(q1, q2);
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("bp_inv", invalid_en, 2'b00);
      chk("bp_hold_valid", issue_valid, 2'b11);
      chk("bp_hold_data1", issue_data1, p1);
      step();
    end
    issue_ready = 1'b1;
    neg(); chk("bp_stall_cnt", perf_stall_cnt, 3); chk("bp_resume_inv", invalid_en, 2'b11);
    push(2'b11, q1, q2);
    step(); set_fifo(32'h0, 32'h0);
    neg(); chk("bp_issue_cnt", perf_issue_cnt, 14);

    // serializing entry with a busy backend
    step(); backend_empty = 1'b0; set_fifo(s1, s2);
    neg(); chk("ser_idle_inv", invalid_en, 2'b00); chk("ser_idle_busy", serial_busy, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("ser_drain_busy", serial_busy, 1'b1);
      chk("ser_drain_inv", invalid_en, 2'b00);
      step();
    end
    backend_empty = 1'b1;
    neg(); chk("ser_drain_state", dbg_state, ST_DRAIN); chk("ser_drain_exit_inv", invalid_en, 2'b00);
    step();
    neg(); chk("ser_issue_inv", invalid_en, 2'b01); push(2'b01, s1, 32'h0);
    step(); set_fifo(s2, s3);
    for (int i = 0; i < 2; i++) begin
      neg();
      chk("ser_wait_inv", invalid_en, 2'b00);
      chk("ser_wait_busy", serial_busy, 1'b1);
      step();
    end
    serial_done = 1'b1;
    neg(); chk("ser_done_inv", invalid_en, 2'b00);
    step(); serial_done = 1'b0;
    neg(); chk("ser_resume_inv", invalid_en, 2'b11); chk("ser_resume_busy", serial_busy, 1'b0);
    push(2'b11, s2, s3);
    step(); set_fifo(32'h0, 32'h0);
    neg(); chk("ser_stall_cnt", perf_stall_cnt, 11); chk("ser_issue_cnt", perf_issue_cnt, 17);

    // flush while waiting on a serializing entry
    step(); set_fifo(u1, u2);
    neg(); chk("fl_idle_inv", invalid_en, 2'b00);
    step();
    neg(); chk("fl_drain_busy", serial_busy, 1'b1);
    step(); issue_ready = 1'b0;
    neg(); chk("fl_issue_inv", invalid_en, 2'b01);
    step(); set_fifo(u2, u3); flush = 1'b1;
    neg();
    chk("fl_inv", invalid_en, 2'b00);
    chk("fl_pre_valid", issue_valid, 2'b01);
    chk("fl_pre_data1", issue_data1, u1);
    chk("fl_pre_busy", serial_busy, 1'b1);
    step(); flush = 1'b0; issue_ready = 1'b1;
    neg();
    chk("fl_post_valid", issue_valid, 2'b00);
    chk("fl_post_busy", serial_busy, 1'b0);
    chk("fl_post_inv", invalid_en, 2'b11);
    push(2'b11, u2, u3);
    step(); set_fifo(32'h0, 32'h0);
    neg(); chk("fl_issue_cnt", perf_issue_cnt, 20); chk("fl_stall_cnt", perf_stall_cnt, 13);

    // asynchronous reset during DRAIN
    step(); backend_empty = 1'b0; set_fifo(r1, 32'h0);
    neg();
    step();
    neg(); chk("ar_drain_busy", serial_busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", serial_busy, 1'b0);
    chk("ar_valid", issue_valid, 2'b00);
    chk("ar_inv", invalid_en, 2'b00);
    chk("ar_issue_cnt", perf_issue_cnt, 0);
    chk("ar_stall_cnt", perf_stall_cnt, 0);
    chk("ar_state", dbg_state, ST_IDLE);

    // recovery after reset
    step(); rst = 1'b1; backend_empty = 1'b1; set_fifo(f1, f2);
    neg(); chk("rec_inv", invalid_en, 2'b11); push(2'b11, f1, f2);
    step(); set_fifo(32'h0, 32'h0);
    neg(); chk("rec_issue_cnt", perf_issue_cnt, 2);
    step();
    neg(); chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dispatch_scheduler.md
Name: dispatch_scheduler

Overview:
Dual-issue dispatch controller between the decode-to-dispatch FIFO and the backend issue stage. Each cycle it inspects the two FIFO head entries and picks 0, 1 or 2 of them to issue. Slot 1 is blocked on intra-pair hazards, structural conflicts and serializing instructions. Chosen entries move into a registered issue stage, and the controller drives the FIFO's invalid_en dequeue vector.

Parameters:
DATA_W, `DECODE_DATA_WIDTH, width of one decoded entry
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (asserted when 0)
flush  in  1  pipeline flush (branch mispredict or exception)
fifo_data1  in  DATA_W  FIFO head entry (dequeue_data1)
fifo_data2  in  DATA_W  FIFO head+1 entry (dequeue_data2)
invalid_en  out  2  dequeue vector to FIFO; bit0 = head, bit1 = head+1
issue_ready  in  1  backend accepts the issue register this cycle
backend_empty  in  1  no instructions in flight after issue
serial_done  in  1  pulse: serializing instruction retired
issue_valid  out  2  registered per-slot valid
issue_data1  out  DATA_W  registered slot-0 entry
issue_data2  out  DATA_W  registered slot-1 entry
serial_busy  out  1  FSM not in IDLE
perf_issue_cnt  out  CNT_W  total instructions issued
perf_stall_cnt  out  CNT_W  cycles with a valid head but zero dequeued

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0.
- Entry fields (bit positions in the shared package):
  - VALID = bit 0; a dequeued FIFO slot reads VALID = 0.
  - RD, RJ, RK: 5 bits each.
  - RD_WEN: 1 bit.
  - CLASS: 3 bits, values ALU, MEM, MULDIV, BR, SERIAL (CSR/priv/ertn/idle/barrier).
- v0 = fifo_data1[VALID], v1 = fifo_data2[VALID]; fifo_empty/full are not used.
- can_load = !issue_valid[0] || issue_ready.
- Slot-0 take (t0): v0 && can_load && !flush && FSM permits.
  - IDLE: entry 0 non-SERIAL.
  - ISSUE_SER: entry 0 SERIAL.
- Slot-1 take (t1): t0 && v1 && FSM == IDLE && entry 1 non-SERIAL. Slot 1 is blocked when any of:
  - (RD_WEN0 && RD0 != 0 && (RD0 == RJ1 || RD0 == RK1)), i.e. a RAW hazard on slot 0's destination;
  - both entries are MEM;
  - both entries are MULDIV.
- invalid_en = {t1, t0}, combinational in the same cycle as the decision.
- Issue register load, when can_load:
  - issue_valid <= {t1, t0};
  - issue_data1/2 <= fifo_data1/2 when the corresponding take is set, else hold.
  - Latency: FIFO head to issue_valid = 1 cycle.
- Flush: invalid_en forced to 0 that cycle. On the next edge: issue_valid <= 0, FSM <= IDLE. Counters are not cleared.
- Serializing FSM:
  - IDLE: if v0 && entry 0 SERIAL && !flush -> DRAIN.
  - DRAIN: wait for backend_empty && !issue_valid[0], then -> ISSUE_SER.
  - ISSUE_SER: issue entry 0 alone when can_load (t0 = 1, t1 = 0) -> WAIT_DONE.
  - WAIT_DONE: nothing issues; serial_done -> IDLE.
  - serial_done in any other state: ignored.
  - flush overrides all transitions.
- A SERIAL entry in slot 1 never pairs. It reaches slot 0 on the following cycle.
- Counters:
  - perf_issue_cnt += t0 + t1;
  - perf_stall_cnt += 1 when v0 && !flush && !t0;
  - both wrap modulo 2^CNT_W.
- Reset mid-serialization: asynchronous return to IDLE; issue register cleared immediately.

Decomposition:
- Package/defines header (alongside defines.vh):
  - field offsets VALID/RD/RJ/RK/RD_WEN/CLASS;
  - CLASS encodings;
  - FSM state encodings IDLE/DRAIN/ISSUE_SER/WAIT_DONE.
- One sub-module, dispatch_pair_check: combinational, takes the two entries and outputs pair_ok (hazard and structural check for slot 1).

Test Plan:
- Two independent ALU entries (RD0 = 5, RJ1 = 6), issue_ready = 1 -> invalid_en = 2'b11; next cycle issue_valid = 2'b11; perf_issue_cnt = 2.
- RAW: RD0 = 7 with RD_WEN = 1, RJ1 = 7 -> invalid_en = 2'b01; next cycle entry 1 issues alone. Same case with RD0 = 0 -> 2'b11.
- Two MEM entries -> 2'b01 then 2'b01. MEM + MULDIV -> 2'b11.
- issue_ready = 0 with issue_valid = 2'b11 and valid head -> invalid_en = 0, issue register holds, perf_stall_cnt increments each cycle.
- CSR in slot 0 with backend_empty = 0 for 3 cycles:
  - serial_busy = 1 and no dequeue during those cycles;
  - backend_empty = 1 -> ISSUE_SER, then invalid_en = 2'b01;
  - WAIT_DONE until serial_done, then pairs resume.
- flush asserted in WAIT_DONE with a valid issue register -> invalid_en = 0 that cycle; next cycle issue_valid = 0, serial_busy = 0. rst = 0 mid-DRAIN -> all outputs 0 asynchronously.
